// File: rtl/gerador_pkg.sv
// gerador_pkg: seletor codes, FSM states, counter width and the HALF mapping
// shared by gerador_frequencia.
package gerador_pkg;

  localparam int CNT_W = 25;

  typedef enum logic [2:0] {
    SEL_INV0   = 3'b000,
    SEL_100KHZ = 3'b001,
    SEL_10KHZ  = 3'b010,
    SEL_1KHZ   = 3'b011,
    SEL_100HZ  = 3'b100,
    SEL_10HZ   = 3'b101,
    SEL_1HZ    = 3'b110,
    SEL_INV7   = 3'b111
  } seletor_t;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ALTO   = 2'd1,
    BAIXO  = 2'd2
  } estado_t;

  function automatic logic codigo_valido(input logic [2:0] code);
    return (code != SEL_INV0) && (code != SEL_INV7);
  endfunction

  // Invalid codes (and degenerate clocks) map to 1 so HALF-1 never underflows.
  function automatic logic [CNT_W-1:0] half_count(input logic [2:0] code,
                                                  input int unsigned clk_hz);
    int unsigned freq;
    case (code)
      SEL_100KHZ: freq = 100_000;
      SEL_10KHZ:  freq = 10_000;
      SEL_1KHZ:   freq = 1_000;
      SEL_100HZ:  freq = 100;
      SEL_10HZ:   freq = 10;
      SEL_1HZ:    freq = 1;
      default:    freq = 0;
    endcase
    if (freq == 0 || clk_hz < 2 * freq) return CNT_W'(1);
    return CNT_W'(clk_hz / (2 * freq));
  endfunction

endpackage

// File: rtl/gerador_frequencia.sv
// gerador_frequencia: selectable-rate 50% square wave with end-of-period strobe.
// Burst mode (rajada/fim) is compiled in only when GERADOR_RAJADA_EN is defined.
module gerador_frequencia
  import gerador_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       habilita,
  input  logic [2:0] seletor,
`ifdef GERADOR_RAJADA_EN
  input  logic [7:0] rajada,
  output logic       fim,
`endif
  output logic       amostra,
  output logic       ciclo,
  output logic       erro
);

  estado_t          r_estado;
  estado_t          w_estado_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel_ativo;
  logic             r_amostra;
  logic             r_ciclo;
  logic             r_erro;

  logic [CNT_W-1:0] w_half_tab [8];
  logic [CNT_W-1:0] w_half_m1;
  logic             w_sel_ok;
  logic             w_term;
  logic             w_pode_iniciar;
  logic             w_fim_rajada;
  logic             w_carrega;
  logic             w_fim_periodo;

  // Constant HALF table, one entry per code; only the active code is selected at run time.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_half
      assign w_half_tab[gi] = half_count(3'(gi), CLK_HZ);
    end
  endgenerate

  assign w_half_m1 = w_half_tab[r_sel_ativo] - CNT_W'(1);
  assign w_term    = (r_cnt == w_half_m1);
  assign w_sel_ok  = codigo_valido(seletor);

`ifdef GERADOR_RAJADA_EN
  logic [7:0] r_rajada;
  logic [7:0] r_periodos;
  logic       r_fim;
  logic       r_bloqueio;

  assign w_pode_iniciar = habilita && w_sel_ok && !r_bloqueio;
  assign w_fim_rajada   = (r_rajada != 8'd0) && (r_periodos == r_rajada - 8'd1);

  // After a finished burst, habilita must be seen low before another start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rajada   <= '0;
      r_periodos <= '0;
      r_fim      <= 1'b0;
      r_bloqueio <= 1'b0;
    end else begin
      r_fim <= w_fim_periodo && w_fim_rajada;
      if (r_estado == OCIOSO && w_pode_iniciar) begin
        r_rajada   <= rajada;
        r_periodos <= '0;
      end else if (w_fim_periodo) begin
        r_periodos <= r_periodos + 8'd1;
      end
      if (w_fim_periodo && w_fim_rajada) begin
        r_bloqueio <= 1'b1;
      end else if (r_estado == OCIOSO && !habilita) begin
        r_bloqueio <= 1'b0;
      end
    end
  end

  assign fim = r_fim;
`else
  assign w_pode_iniciar = habilita && w_sel_ok;
  assign w_fim_rajada   = 1'b0;
`endif

  always_comb begin
    w_estado_next = r_estado;
    w_carrega     = 1'b0;
    w_fim_periodo = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (w_pode_iniciar) begin
          w_estado_next = ALTO;
          w_carrega     = 1'b1;
        end
      end
      ALTO: begin
        if (w_term) w_estado_next = BAIXO;
      end
      BAIXO: begin
        if (w_term) begin
          w_fim_periodo = 1'b1;
          if (habilita && w_sel_ok && !w_fim_rajada) begin
            w_estado_next = ALTO;
            w_carrega     = 1'b1;
          end else begin
            w_estado_next = OCIOSO;
          end
        end
      end
      default: w_estado_next = OCIOSO;
    endcase
  end

  // seletor is only taken at a period boundary, so a mid-period change never shortens a half.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado    <= OCIOSO;
      r_cnt       <= '0;
      r_sel_ativo <= 3'b001;
      r_amostra   <= 1'b0;
      r_ciclo     <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      r_estado <= w_estado_next;
      if (w_estado_next != r_estado || r_estado == OCIOSO) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_carrega) r_sel_ativo <= seletor;
      r_amostra <= (w_estado_next == ALTO);
      r_ciclo   <= w_fim_periodo;
      if (r_estado == OCIOSO || w_fim_periodo) r_erro <= !w_sel_ok;
    end
  end

  assign amostra = r_amostra;
  assign ciclo   = r_ciclo;
  assign erro    = r_erro;

endmodule

// File: doc/gerador_frequencia.md
GERADOR_FREQUENCIA -- requirements
Module: gerador_frequencia

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 clk  input  1  system clock; the block uses only this clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 habilita  input  1  run request; 1 = generate, 0 = stop at the end of the current period.
REQ-005 seletor  input  3  frequency code: 001=100 kHz, 010=10 kHz, 011=1 kHz, 100=100 Hz, 101=10 Hz, 110=1 Hz; 000 and 111 are invalid.
REQ-006 amostra  output  1  registered square-wave output at 50% duty.
REQ-007 ciclo  output  1  one-cycle strobe marking the end of each completed period.
REQ-008 erro  output  1  registered flag; 1 while the sampled seletor code is invalid.

Function
REQ-009 Half-period count SHALL be HALF = CLK_HZ/(2*f_sel), using integer division.
- At the default CLK_HZ: 250, 2500, 25000, 250000, 2500000, 25000000.
REQ-010 The counter SHALL be 25 bits wide, SHALL count 0..HALF-1, and SHALL clear to 0 on every state change.
REQ-011 The FSM SHALL have three states: OCIOSO, ALTO, BAIXO.
- amostra = 1 only in ALTO.
REQ-012 OCIOSO: if habilita=1 and seletor is valid, latch seletor into seletor_ativo and enter ALTO on the next edge.
- amostra rises 1 cycle after habilita is sampled.
REQ-013 ALTO: at cnt==HALF-1, enter BAIXO.
REQ-014 BAIXO: at cnt==HALF-1, pulse ciclo for 1 cycle.
- If habilita=1 and seletor is valid: latch the new seletor and re-enter ALTO.
- Otherwise: enter OCIOSO.
REQ-015 The period SHALL be exactly 2*HALF cycles of seletor_ativo.
- A seletor change mid-period SHALL take effect only at the next period boundary, so no runt pulse occurs.
REQ-016 A habilita drop during ALTO or BAIXO SHALL NOT truncate the current period.
REQ-017 erro SHALL be updated wherever seletor is sampled (OCIOSO each cycle; BAIXO at the terminal count).
- An invalid code at a boundary SHALL stop the output (go to OCIOSO) and set erro=1.
REQ-018 habilita rising and falling in the same OCIOSO cycle SHALL still start one full period.

Reset
REQ-019 On rst=1 at a clk edge:
- state=OCIOSO, cnt=0, seletor_ativo=001;
- amostra=0, ciclo=0, erro=0 (plus burst registers, when compiled in).
REQ-020 rst SHALL override all other inputs, including mid-period.
- amostra is low on the first cycle after reset.

Configuration
REQ-021 Macro GERADOR_RAJADA_EN, when defined, SHALL add:
- input rajada[7:0], the burst length in periods, latched at start; 0 = continuous;
- output fim, a 1-cycle pulse.
REQ-022 With GERADOR_RAJADA_EN and rajada=N>0, the block SHALL stop after N completed periods:
- enter OCIOSO and pulse fim in the same cycle as the Nth ciclo strobe;
- not restart until habilita has been sampled 0 for at least 1 cycle.
REQ-023 Without GERADOR_RAJADA_EN, the rajada and fim ports and their logic SHALL be absent, and generation is continuous.

Structure
REQ-024 Package gerador_pkg SHALL hold:
- the seletor code constants (typedef enum, 3 bits);
- the FSM state typedef;
- a function mapping code and CLK_HZ to HALF;
- the counter width constant (25).
REQ-025 The block SHALL be a single module with no sub-module.
- The divider counter is inline; the block is small enough not to warrant one.

Verification
REQ-026 CLK_HZ=50e6, seletor=001, habilita=1 -> amostra high 250 cycles, low 250 cycles, repeating; ciclo every 500 cycles.
REQ-027 seletor 010 -> 011 written at cycle 100 of an ALTO half -> current period stays 5000 cycles; the next period is 50000 cycles.
REQ-028 habilita=0 at cycle 10 of ALTO (seletor=001) -> remaining 240 high and 250 low cycles complete; then OCIOSO, amostra=0.
REQ-029 seletor=000 with habilita=1 -> amostra stays 0 and erro=1 from the next cycle; seletor=110 -> erro=0 and amostra rises 1 cycle later.
REQ-030 rst=1 at cycle 50 of ALTO -> amostra=0, ciclo=0, erro=0 next cycle; after release, amostra restarts 1 cycle after habilita is sampled.
REQ-031 With GERADOR_RAJADA_EN, rajada=3, seletor=001 -> exactly 3 periods (1500 cycles), fim with the third ciclo, no restart while habilita stays 1.
